// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU op codes, sequencer state encodings and the double-width bus helper.
// Pure constants and functions; no latency or backpressure of its own.
package mdu_ctrl_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // HI:LO result bus width for a given register width.
  function automatic int double_bus_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on operand magnitudes.
// Result in acc WIDTH steps after load; no backpressure, steps only when told to.
module mdu_datapath
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             step,
  input  logic                             is_div,
  input  logic [WIDTH-1:0]                 op_a,
  input  logic [WIDTH-1:0]                 op_b,
  output logic [double_bus_w(WIDTH)-1:0]   acc
);

  localparam int DW = double_bus_w(WIDTH);

  logic [DW-1:0]    acc_q;
  logic [DW-1:0]    acc_nxt;
  logic [WIDTH-1:0] oper_q;
  logic             div_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH+1:0] trial;

  // acc holds {partial product | multiplier} or {remainder | dividend->quotient}.
  always_comb begin
    add_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : {(WIDTH+1){1'b0}});
    part_rem = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    trial    = {1'b0, part_rem} - {2'b00, oper_q};
    acc_nxt  = {add_sum, acc_q[WIDTH-1:1]};
    if (div_q) begin
      if (trial[WIDTH+1])
        acc_nxt = {part_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      oper_q <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      acc_q  <= is_div ? {{WIDTH{1'b0}}, op_a} : {{WIDTH{1'b0}}, op_b};
      oper_q <= is_div ? op_b : op_a;
      div_q  <= is_div;
    end else if (step) begin
      acc_q  <= acc_nxt;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mdu_ctrl.sv
// MULT/DIV sequencer: stalls fetch, runs WIDTH engine steps, writes HI/LO once (WIDTH+1 cycles, 1 for /0).
// Backpressure via stall_o; DONE-phase result write overrides the WB HI/LO write port.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             cancel_i,
  input  logic             wb_whilo_i,
  input  logic [WIDTH-1:0] wb_hi_i,
  input  logic [WIDTH-1:0] wb_lo_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  localparam int DW = double_bus_w(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             rsign_q;
  logic             div_q;
  logic             dbz_q;
  logic [WIDTH-1:0] dz_hi_q;

  logic             signed_op;
  logic             div_op;
  logic             div_zero;
  logic             launch;
  logic             in_done;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [DW-1:0]    acc;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign div_op    = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
  assign div_zero  = div_op && (opdata2_i == '0);
  assign launch    = (state == S_IDLE) && start_i && !cancel_i;
  assign in_done   = (state == S_DONE);
  assign mag_a     = (signed_op && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag_b     = (signed_op && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
      dz_hi_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            cnt     <= '0;
            sign_q  <= signed_op && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rsign_q <= signed_op && opdata1_i[WIDTH-1];
            div_q   <= div_op;
            dbz_q   <= div_zero;
            dz_hi_q <= opdata1_i;
            state   <= div_zero ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (cancel_i) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1))
              state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (launch && !div_zero),
    .step   (state == S_BUSY),
    .is_div (div_op),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (acc)
  );

  // Engine works on magnitudes; signs are restored only on the way out.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (dbz_q) begin
      res_hi = dz_hi_q;
      res_lo = '1;
    end else if (div_q) begin
      res_lo = sign_q  ? -acc[WIDTH-1:0]  : acc[WIDTH-1:0];
      res_hi = rsign_q ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];
    end else begin
      {res_hi, res_lo} = sign_q ? -acc : acc;
    end
  end

  assign stall_o = !rst && (((state == S_IDLE) && start_i) || (state == S_BUSY));
  assign busy_o  = (state != S_IDLE);
  assign whilo_o = in_done ? !cancel_i : (!rst && wb_whilo_i);
  assign hi_o    = in_done ? res_hi : (rst ? '0 : wb_hi_i);
  assign lo_o    = in_done ? res_lo : (rst ? '0 : wb_lo_i);
  assign dbz_o   = in_done && dbz_q && !cancel_i;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboarded random/directed bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        cancel_i = 1'b0;
  logic        wb_whilo_i = 1'b0;
  logic [31:0] wb_hi_i = '0;
  logic [31:0] wb_lo_i = '0;
  logic        stall_o, busy_o, whilo_o, dbz_o;
  logic [31:0] hi_o, lo_o;

  mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .cancel_i(cancel_i),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .stall_o(stall_o), .busy_o(busy_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .dbz_o(dbz_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t scb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sbv, p, q, r;
    logic [63:0] v, vq, vr;
    e.dbz = 1'b0;
    e.cyc = 0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      MDU_MULT: begin
        p = sa * sbv;
        v = p;
        e.hi = v[63:32];
        e.lo = v[31:0];
      end
      MDU_MULTU: begin
        v = {32'd0, a} * {32'd0, b};
        e.hi = v[63:32];
        e.lo = v[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.dbz = 1'b1;
          e.hi  = a;
          e.lo  = 32'hFFFF_FFFF;
        end else if (op == MDU_DIV) begin
          q  = sa / sbv;
          r  = sa % sbv;
          vq = q;
          vr = r;
          e.lo = vq[31:0];
          e.hi = vr[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every HI/LO write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (whilo_o) begin
        if (scb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_whilo: got hi=0x%0h lo=0x%0h, expected no write (t=%0t)", hi_o, lo_o, $time);
        end else begin
          mon_e = scb.pop_front();
          chk("hi", 64'(hi_o), 64'(mon_e.hi));
          chk("lo", 64'(lo_o), 64'(mon_e.lo));
          chk("dbz", 64'(dbz_o), 64'(mon_e.dbz));
          chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else if (dbz_o) begin
        chk("dbz_without_whilo", 64'(dbz_o), 64'd0);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit wbc);
    exp_t e;
    int c0, lat, n;
    bit done;
    @(posedge clk); #1;
    e   = model(op, a, b);
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    c0  = cyc;
    e.cyc = c0 + lat;
    scb.push_back(e);
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (stall_o) n++;
      else begin
        done = 1'b1;
        chk("busy_in_done", 64'(busy_o), 64'd1);
      end
      if (!done) begin
        @(posedge clk); #1;
        if (wbc && cyc == c0 + lat) begin
          wb_whilo_i = 1'b1; wb_hi_i = $urandom; wb_lo_i = $urandom;
        end
      end
    end
    chk("stall_cycles", 64'(n), 64'(lat));
    @(posedge clk); #1;
    start_i = 1'b0; wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;
  endtask

  task automatic cancel_op(input int cancel_at);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = MDU_MULTU; opdata1_i = $urandom; opdata2_i = $urandom;
    repeat (cancel_at) @(posedge clk);
    #1 cancel_i = 1'b1;
    @(negedge clk);
    chk("whilo_under_cancel", 64'(whilo_o), 64'd0);
    @(posedge clk); #1;
    cancel_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("cancel_stall", 64'(stall_o), 64'd0);
    chk("cancel_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic reset_mid_busy();
    @(posedge clk); #1;
    start_i = 1'b1; op_i = MDU_MULT; opdata1_i = $urandom; opdata2_i = $urandom;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; start_i = 1'b0;
    #1;
    chk("rst_ctl", 64'({stall_o, busy_o, whilo_o, dbz_o}), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    @(posedge clk); #1;
    e.hi = h; e.lo = l; e.dbz = 1'b0; e.cyc = cyc;
    scb.push_back(e);
    wb_whilo_i = 1'b1; wb_hi_i = h; wb_lo_i = l;
    @(posedge clk); #1;
    wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", 64'({stall_o, busy_o, whilo_o, dbz_o}), 64'd0);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_ctl", 64'({stall_o, busy_o, whilo_o, dbz_o}), 64'd0);

    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(MDU_DIVU,  32'd100, 32'd7, 1'b0);
    run_op(MDU_DIVU,  32'd5, 32'd0, 1'b0);
    run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MDU_DIV,   32'hFFFF_FFF0, 32'd0, 1'b1);

    cancel_op(10);
    run_op(MDU_DIVU, 32'd9, 32'd3, 1'b0);
    cancel_op(33);
    reset_mid_busy();
    run_op(MDU_DIVU, 32'd9, 32'd3, 1'b0);

    wb_write(32'h0000_00AA, 32'h0000_0055);
    for (int i = 0; i < 3; i++) wb_write($urandom, $urandom);
    run_op(MDU_MULTU, $urandom, $urandom, 1'b1);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(scb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before t=2000000");
    $fatal(1, "timeout");
  end

endmodule
